// File: rtl/fetch_decode_queue.sv
// Fetch->decode circular queue of {instr, pc, pc_plus_4}; 1-cycle latency, 0 with FETCH_QUEUE_BYPASS_EN.
// Backpressure: in_ready drops when full or flushing; a same-cycle pop never frees room for a push.
module fetch_decode_queue #(
  parameter int                   XLEN      = 32,
  parameter int                   INSTR_LEN = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [INSTR_LEN-1:0] NOP_INSTR = INSTR_LEN'(32'h00000013)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_LEN-1:0]      in_instr,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_pc_plus_4,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_LEN-1:0]      out_instr,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_pc_plus_4,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [INSTR_LEN-1:0] r_mem_instr [DEPTH];
  logic [XLEN-1:0]      r_mem_pc    [DEPTH];
  logic [XLEN-1:0]      r_mem_pc4   [DEPTH];

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;

  logic w_full;
  logic w_empty;
  logic w_head_vld;
  logic w_bypass;
  logic w_push;
  logic w_wr;
  logic w_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty    = (r_rd_ptr == r_wr_ptr);
  assign w_full     = (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]) &&
                      (r_rd_ptr[AW] != r_wr_ptr[AW]);
  assign w_head_vld = !w_empty;
  assign count      = r_wr_ptr - r_rd_ptr;

  assign in_ready = !w_full && !flush;
  assign w_push   = in_valid && in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && in_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry that decode takes immediately is never stored.
  assign w_wr      = w_push && !(w_bypass && out_ready);
  assign w_pop     = w_head_vld && out_ready && !flush;
  assign out_valid = w_head_vld || w_bypass;

  always_comb begin
    out_instr     = NOP_INSTR;
    out_pc        = '0;
    out_pc_plus_4 = '0;
    if (w_bypass) begin
      out_instr     = in_instr;
      out_pc        = in_pc;
      out_pc_plus_4 = in_pc_plus_4;
    end else if (w_head_vld) begin
      out_instr     = r_mem_instr[r_rd_ptr[AW-1:0]];
      out_pc        = r_mem_pc[r_rd_ptr[AW-1:0]];
      out_pc_plus_4 = r_mem_pc4[r_rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_wr) begin
      r_mem_instr[r_wr_ptr[AW-1:0]] <= in_instr;
      r_mem_pc[r_wr_ptr[AW-1:0]]    <= in_pc;
      r_mem_pc4[r_wr_ptr[AW-1:0]]   <= in_pc_plus_4;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue (DEPTH=4); covers bypass build when FETCH_QUEUE_BYPASS_EN is defined.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_pc_plus_4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  fetch_decode_queue #(.XLEN(32), .INSTR_LEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .count(count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] pc);
    in_valid     = v;
    in_pc        = pc;
    in_instr     = {16'hA5A5, pc[15:0]};
    in_pc_plus_4 = pc + 32'd4;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drv(1'b0, 32'h0);
    cyc(); cyc();
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== NOP) begin failures++; $display("FAIL reset_out_instr got=%h exp=%h", out_instr, NOP); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_pc_plus_4 !== 32'h0) begin failures++; $display("FAIL reset_out_pc4 got=%h exp=0", out_pc_plus_4); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'(i * 4));
      cyc();
      #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
        failures++; $display("FAIL fill_head[%0d] got vld=%b pc=%h exp vld=1 pc=0", i, out_valid, out_pc); end
      checks++; if (count !== 3'(i + 1)) begin
        failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
    end
    // Full: push must be refused and stay a no-op.
    drv(1'b1, 32'h99);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    cyc();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_push_noop got=%0d exp=4", count); end
    // Pop on full with push offered: no pass-through, count drops to 3.
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'hA5A50000 || out_pc_plus_4 !== 32'h4) begin
      failures++; $display("FAIL drain_0 got pc=%h instr=%h pc4=%h exp pc=0 instr=a5a50000 pc4=4", out_pc, out_instr, out_pc_plus_4); end
    cyc();
    drv(1'b0, 32'h0);
    #1;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_pop_count got=%0d exp=3", count); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_pc_plus_4 !== 32'(i * 4 + 4)) begin
        failures++; $display("FAIL drain_%0d got vld=%b pc=%h pc4=%h exp pc=%h", i, out_valid, out_pc, out_pc_plus_4, i * 4); end
      cyc();
    end
    checks++; if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0) begin
      failures++; $display("FAIL drain_empty got vld=%b instr=%h pc=%h exp vld=0 nop pc=0", out_valid, out_instr, out_pc); end
    cyc();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_pop_noop got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    drv(1'b1, 32'h00); cyc();
    drv(1'b1, 32'h04); cyc();
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      drv(1'b1, 32'(i * 4));
      #1;
      checks++; if (out_pc !== 32'((i - 2) * 4) || count !== 3'd2) begin
        failures++; $display("FAIL wrap_%0d got pc=%h cnt=%0d exp pc=%h cnt=2", i, out_pc, count, (i - 2) * 4); end
      cyc();
    end
    drv(1'b0, 32'h0);
    #1;
    checks++; if (out_pc !== 32'h20) begin failures++; $display("FAIL wrap_tail0 got=%h exp=20", out_pc); end
    cyc();
    checks++; if (out_pc !== 32'h24) begin failures++; $display("FAIL wrap_tail1 got=%h exp=24", out_pc); end
    cyc();
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL wrap_end got vld=%b cnt=%0d exp vld=0 cnt=0", out_valid, count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drv(1'b1, 32'h200); cyc();
    drv(1'b1, 32'h204); cyc();
    drv(1'b1, 32'h208); cyc();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    flush = 1'b1; out_ready = 1'b1;
    drv(1'b1, 32'h20C);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    cyc();
    flush = 1'b0; out_ready = 1'b0;
    drv(1'b0, 32'h0);
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_after got cnt=%0d vld=%b exp cnt=0 vld=0", count, out_valid); end
    drv(1'b1, 32'h100); cyc();
    drv(1'b0, 32'h0);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || count !== 3'd1) begin
      failures++; $display("FAIL flush_next got vld=%b pc=%h cnt=%0d exp vld=1 pc=100 cnt=1", out_valid, out_pc, count); end
    out_ready = 1'b1; cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_alone got vld=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'(32'h300 + i * 4)); cyc();
    end
    drv(1'b0, 32'h0);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL rmid_pre got=%0d exp=4", count); end
    reset = 1'b0; cyc(); reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_instr !== NOP) begin
      failures++; $display("FAIL rmid_after got cnt=%0d rdy=%b vld=%b instr=%h exp 0/1/0/nop", count, in_ready, out_valid, out_instr); end
    drv(1'b1, 32'h400); cyc();
    drv(1'b0, 32'h0);
    #1;
    checks++; if (out_pc !== 32'h400 || count !== 3'd1) begin
      failures++; $display("FAIL rmid_new got pc=%h cnt=%0d exp pc=400 cnt=1", out_pc, count); end
    out_ready = 1'b1; cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_drain got vld=%b exp=0", out_valid); end
  endtask

  task automatic test_bypass();
    out_ready = 1'b1;
    drv(1'b1, 32'h40);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || count !== 3'd0) begin
      failures++; $display("FAIL bypass_same got vld=%b pc=%h cnt=%0d exp vld=1 pc=40 cnt=0", out_valid, out_pc, count); end
    cyc();
    drv(1'b0, 32'h0);
    #1;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL bypass_next got vld=%b cnt=%0d exp vld=0 cnt=0", out_valid, count); end
`else
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_same got vld=%b exp=0", out_valid); end
    cyc();
    drv(1'b0, 32'h0);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || count !== 3'd1) begin
      failures++; $display("FAIL nobypass_next got vld=%b pc=%h cnt=%0d exp vld=1 pc=40 cnt=1", out_valid, out_pc, count); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nobypass_drain got vld=%b exp=0", out_valid); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
